// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: sequencer states,
// Booth decision codes and the control-word decode used by booth_ctrl.
package booth_pkg;

  localparam int N_DEFAULT = 8;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_M = 4'd1,
    LOAD_Q = 4'd2,
    INIT   = 4'd3,
    CHECK  = 4'd4,
    ADD    = 4'd5,
    SUB    = 4'd6,
    SHIFT  = 4'd7,
    OUT_A  = 4'd8,
    OUT_Q  = 4'd9,
    DONE   = 4'd10
  } state_e;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] c;
  } ctrl_t;

  // Strobe pattern owned by each state; at most one c bit is ever set.
  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t v;
    v      = '{busy: 1'b1, done: 1'b0, c: 8'h00};
    case (s)
      IDLE:    v.busy = 1'b0;
      LOAD_M:  v.c    = 8'h01;
      LOAD_Q:  v.c    = 8'h02;
      INIT:    v.c    = 8'h04;
      CHECK:   v.c    = 8'h00;
      ADD:     v.c    = 8'h08;
      SHIFT:   v.c    = 8'h10;
      SUB:     v.c    = 8'h20;
      OUT_A:   v.c    = 8'h40;
      OUT_Q:   v.c    = 8'h80;
      DONE:    v.done = 1'b1;
      default: v      = '{busy: 1'b0, done: 1'b0, c: 8'h00};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/booth_ctrl.sv
// Radix-2 Booth sequencer: walks LOAD/INIT, then N CHECK/(ADD|SUB)/SHIFT
// iterations, then unloads A and Q and pulses done.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_lsb,
  output logic busy,
  output logic done,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7
);

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  ctrl_t         ctrl_q;

  // Next-state and iteration-count logic; q0/q_lsb only matter in CHECK.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_M;
        else       state_d = IDLE;
      end
      LOAD_M: state_d = LOAD_Q;
      LOAD_Q: state_d = INIT;
      INIT: begin
        state_d = CHECK;
        count_d = {CW{1'b0}};
      end
      CHECK: begin
        case ({q0, q_lsb})
          BOOTH_ADD: state_d = ADD;
          BOOTH_SUB: state_d = SUB;
          default:   state_d = SHIFT;
        endcase
      end
      ADD:   state_d = SHIFT;
      SUB:   state_d = SHIFT;
      SHIFT: begin
        if (count_q == LAST_ITER) begin
          state_d = OUT_A;
        end else begin
          state_d = CHECK;
          count_d = count_q + CW'(1);
        end
      end
      OUT_A:   state_d = OUT_Q;
      OUT_Q:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control word is registered from the next state, so it always equals
  // the decode of the current state with no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= {CW{1'b0}};
      ctrl_q  <= '{busy: 1'b0, done: 1'b0, c: 8'h00};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ctrl_q  <= decode_state(state_d);
    end
  end

  assign busy = ctrl_q.busy;
  assign done = ctrl_q.done;
  assign c0   = ctrl_q.c[0];
  assign c1   = ctrl_q.c[1];
  assign c2   = ctrl_q.c[2];
  assign c3   = ctrl_q.c[3];
  assign c4   = ctrl_q.c[4];
  assign c5   = ctrl_q.c[5];
  assign c6   = ctrl_q.c[6];
  assign c7   = ctrl_q.c[7];

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl: per-cycle strobe schedules for shift-only,
// add and subtract runs, reset, ignored start and back-to-back operation.
module tb_booth_ctrl;

  logic clk = 1'b0;
  logic rst, start, q0, q_lsb;
  logic busy, done, c0, c1, c2, c3, c4, c5, c6, c7;

  int n_cmp = 0;
  int n_bad = 0;

  booth_ctrl #(.N(8), .CW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .q_lsb(q_lsb),
    .busy(busy), .done(done),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] obs();
    return {busy, done, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  // Hand schedule: mode 0 shift-only, 1 add, 2 sub; rel=1 is the LOAD_M cycle.
  function automatic logic [9:0] exp_vec(input int mode, input int rel);
    int p, tail, off;
    logic [9:0] v;
    p    = (mode == 0) ? 2 : 3;
    tail = 4 + 8 * p;
    v    = 10'h000;
    if (rel == 1) v[0] = 1'b1;
    if (rel == 2) v[1] = 1'b1;
    if (rel == 3) v[2] = 1'b1;
    if (rel >= 4 && rel < tail) begin
      off = (rel - 4) % p;
      if (p == 2 && off == 1) v[4] = 1'b1;
      if (p == 3 && off == 1) v[(mode == 1) ? 3 : 5] = 1'b1;
      if (p == 3 && off == 2) v[4] = 1'b1;
    end
    if (rel == tail)     v[6] = 1'b1;
    if (rel == tail + 1) v[7] = 1'b1;
    if (rel == tail + 2) v[8] = 1'b1;
    if (rel >= 1 && rel <= tail + 2) v[9] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a whole run from its LOAD_M cycle through the following IDLE cycle.
  // start is pulsed at rel p1/p2 and forced low at rel off_rel (0 = unused).
  task automatic expect_run(input string tag, input int mode, input int p1,
                            input int p2, input int off_rel);
    int tail, n4, n35, ndone;
    logic pulsed;
    tail  = 4 + 8 * ((mode == 0) ? 2 : 3);
    n4    = 0;
    n35   = 0;
    ndone = 0;
    for (int rel = 1; rel <= tail + 3; rel++) begin
      check_eq(tag, {22'd0, obs()}, {22'd0, exp_vec(mode, rel)});
      check_eq({tag, "_onehot"}, {31'd0, ($countones({c7, c6, c5, c4, c3, c2, c1, c0}) <= 1)}, 32'd1);
      n4    += int'(c4);
      n35   += int'(c3) + int'(c5);
      ndone += int'(done);
      pulsed = 1'b0;
      if (rel == p1 || rel == p2) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else if (rel == off_rel) begin
        start = 1'b0;
      end else begin
        pulsed = 1'b0;
      end
      tick();
      if (pulsed) start = 1'b0;
    end
    check_eq({tag, "_c4_pulses"}, n4, 32'd8);
    check_eq({tag, "_addsub_pulses"}, n35, (mode == 0) ? 32'd0 : 32'd8);
    check_eq({tag, "_done_pulses"}, ndone, 32'd1);
  endtask

  task automatic set_q(input int mode);
    q0    = (mode == 2) ? 1'b1 : 1'b0;
    q_lsb = (mode == 1) ? 1'b1 : 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    q0    = 1'bx;
    q_lsb = 1'bx;

    // Reset and idle
    tick();
    tick();
    check_eq("reset_state", {22'd0, obs()}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_hold", {22'd0, obs()}, 32'd0);
    end

    // Shift-only, add-every, subtract-every runs
    set_q(0);
    pulse_start();
    expect_run("shift_only", 0, 0, 0, 0);
    set_q(1);
    pulse_start();
    expect_run("add_every", 1, 0, 0, 0);
    set_q(2);
    pulse_start();
    expect_run("sub_every", 2, 0, 0, 0);

    // Reset during the third SHIFT cycle (rel 9)
    set_q(0);
    pulse_start();
    for (int rel = 1; rel <= 9; rel++) begin
      check_eq("midrst_pre", {22'd0, obs()}, {22'd0, exp_vec(0, rel)});
      if (rel < 9) tick();
    end
    rst = 1'b1;
    tick();
    check_eq("midrst_cleared", {22'd0, obs()}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("midrst_idle", {22'd0, obs()}, 32'd0);
    pulse_start();
    expect_run("after_midrst", 0, 0, 0, 0);

    // start pulsed in CHECK (rel 4) and DONE (rel 22) must be ignored
    pulse_start();
    expect_run("start_ignored", 0, 4, 22, 0);
    for (int i = 0; i < 5; i++) begin
      check_eq("no_requeue", {22'd0, obs()}, 32'd0);
      tick();
    end

    // start held high: back-to-back runs, LOAD_M right after one IDLE cycle
    start = 1'b1;
    tick();
    expect_run("b2b_first", 0, 0, 0, 0);
    expect_run("b2b_second", 0, 0, 0, 23);
    for (int i = 0; i < 3; i++) begin
      check_eq("b2b_stop", {22'd0, obs()}, 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
